// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    // ALU operation class requested by the FSM; FUNCT defers to the funct field
    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'd0,
        ALUOP_ADD   = 2'd1,
        ALUOP_SUB   = 2'd2,
        ALUOP_FUNCT = 2'd3
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps ALU operation class and funct to alu_control
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       funct_legal_o
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_ctrl    = ALU_AND;
        funct_legal_o = 1'b1;
        case (funct_i)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_legal_o = 1'b0;
        endcase
    end

    always_comb begin
        alu_control_o = 3'b000;
        case (alu_op_i)
            ALUOP_ADD:   alu_control_o = ALU_ADD;
            ALUOP_SUB:   alu_control_o = ALU_SUB;
            ALUOP_FUNCT: alu_control_o = funct_legal_o ? funct_ctrl : 3'b000;
            default:     alu_control_o = 3'b000;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS main controller FSM
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       last;
    alu_op_t    alu_op;
    logic       funct_legal;

`ifdef MC_CTRL_BNE_EN
    logic is_bne_q, is_bne_d;
`endif

    mc_alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (funct),
        .alu_control_o (alu_control),
        .funct_legal_o (funct_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_START;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef MC_CTRL_BNE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) is_bne_q <= 1'b0;
        else     is_bne_q <= is_bne_d;
    end
`endif

    assign last    = (wait_q == WAIT_LAST);
    assign state_o = state_q;

    always_comb begin
        state_d       = state_q;
        wait_d        = 4'd0;
        alu_op        = ALUOP_NONE;
        iord          = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_src        = PCSRC_ALURESULT;
        pc_en         = 1'b0;
        illegal_instr = 1'b0;
`ifdef MC_CTRL_BNE_EN
        is_bne_d      = is_bne_q;
`endif
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
`ifdef MC_CTRL_BNE_EN
                is_bne_d  = 1'b0;
`endif
                // PC+4 and the IR load happen only once, on the final wait cycle
                if (last) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH2;
                alu_op    = ALUOP_ADD;
`ifdef MC_CTRL_BNE_EN
                is_bne_d  = (opcode == OP_BNE);
`endif
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal) state_d = S_EXECUTE;
                        else             illegal_instr = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  state_d = S_BRANCH;
`endif
                    default: illegal_instr = 1'b1;
                endcase
                if (illegal_instr) state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (last) state_d = S_MEMWB;
                else      wait_d  = wait_q + 4'd1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (last) state_d = S_FETCH;
                else      wait_d  = wait_q + 4'd1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
                pc_en     = zero ^ is_bne_q;
`else
                pc_en     = zero;
`endif
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PCSRC_JUMP;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_START;
        endcase
    end

endmodule
